monolith_round_scheduler: RTL and testbench
===========================================

// Module: monolith_round_scheduler
// PURPOSE
//  Sequences one monolith_round pipeline through NUM_ROUNDS iterations of a single permutation.
//  Accepts a state on a valid/ready input and fetches each round's constants from a synchronous ROM.
//  Issues the state to the round, collects the result, feeds it back, then presents the final
//  state on a valid/ready output. One permutation in flight at a time, so constants stay stable
//  while a round is in the pipeline.
// PARAMETERS
//  WORD_WIDTH      31  field element width (bits)
//  STATE_SIZE      16  words per state
//  NUM_ROUNDS       6  round iterations per permutation (>=2)
//  LAST_ROUND_ZERO  1  1: final round uses all-zero constants and ignores rc_data
//  TIMEOUT_CYCLES 64  watchdog limit per round, in cycles (used only with the watchdog macro)
// PORTS
//  clk              in   1                       clock, rising edge
//  reset            in   1                       asynchronous, active-low (0 = in reset)
//  in_state         in   WORD_WIDTH x STATE_SIZE state to permute
//  in_valid         in   1                       in_state is valid
//  in_ready         out  1                       scheduler can accept a state
//  out_state        out  WORD_WIDTH x STATE_SIZE permuted state
//  out_valid        out  1                       out_state is valid
//  out_ready        in   1                       consumer accepts out_state
//  rc_addr          out  $clog2(NUM_ROUNDS)      constant ROM round index
//  rc_data          in   WORD_WIDTH x STATE_SIZE ROM data, valid 1 cycle after rc_addr
//  round_state_in   out  WORD_WIDTH x STATE_SIZE to round pipeline (= internal state reg)
//  round_in_valid   out  1                       1-cycle issue pulse
//  round_constants  out  WORD_WIDTH x STATE_SIZE registered constants, stable through the round
//  round_state_out  in   WORD_WIDTH x STATE_SIZE from round pipeline
//  round_out_valid  in   1                       round result valid
//  busy             out  1                       high when FSM != IDLE
//  err              out  1                       watchdog fired (sticky)
// BEHAVIOUR
//  Reset: FSM=IDLE; round_cnt=0; every output 0 except in_ready=1; state and constant regs cleared.
//   Reset mid-permutation abandons the state. No output is produced for it.
//  FSM transitions:
//   IDLE:  in_ready=1; on in_valid -> capture in_state, round_cnt=0, go to FETCH.
//   FETCH: rc_addr=round_cnt (registered); go to LATCH.
//   LATCH: round_constants <= (LAST_ROUND_ZERO && round_cnt==NUM_ROUNDS-1) ? 0 : rc_data;
//          go to ISSUE.
//   ISSUE: round_in_valid=1 for exactly this cycle; go to WAIT.
//   WAIT:  on round_out_valid -> state <= round_state_out.
//          If round_cnt==NUM_ROUNDS-1, go to DONE; else round_cnt++ and go to FETCH.
//   DONE:  out_valid=1 and out_state=state, held stable; on out_ready -> IDLE.
//          in_ready is 0 in DONE. No bypass: the next accept happens in IDLE, 1 cycle later.
//  Latency: 1 + NUM_ROUNDS*(3 + L_round) cycles from accept to out_valid.
//   L_round = round pipeline issue-to-valid latency.
//  Boundary rules:
//   - round_out_valid outside WAIT is ignored.
//   - round_constants and round_state_in never change during WAIT.
//   - out_ready while out_valid=0 has no effect.
//   - in_valid outside IDLE is not consumed.
// CONFIGURATION
//  MONOLITH_SCHED_WATCHDOG_EN defined:
//   - A cycle counter clears on entry to WAIT.
//   - If it reaches TIMEOUT_CYCLES with no round_out_valid, the FSM enters ERROR and err=1.
//   - ERROR holds in_ready=0 and out_valid=0 until reset.
//  Not defined: no counter and no ERROR state; err tied 0; WAIT waits indefinitely.
// STRUCTURE
//  monolith_pkg:
//   - WORD_WIDTH/STATE_SIZE defaults
//   - typedef state_t = logic [WORD_WIDTH-1:0] [0:STATE_SIZE-1]
//   - enum sched_state_e {IDLE,FETCH,LATCH,ISSUE,WAIT,DONE,ERROR}
//  Sub-module monolith_sched_watchdog: counter with clear, enable and expired flag;
//   instantiated only under the macro.
// TESTING (bench: stub round with L_round=5, ROM word = 0x100*round+index, NUM_ROUNDS=6)
//  1. Reset, then in_state = all 1 with in_valid
//     -> in_ready drops next cycle; rc_addr steps 0..5.
//     -> out_valid at cycle 1+6*8=49 with the golden-model result.
//  2. Round 5 with LAST_ROUND_ZERO=1 -> round_constants = 0 during the 6th ISSUE/WAIT.
//     With LAST_ROUND_ZERO=0 -> constants = 0x500+i.
//  3. Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state stable.
//     Then pulse out_ready -> in_ready=1 next cycle.
//  4. Inject round_out_valid during FETCH -> state unchanged, result unchanged.
//     Back-to-back inputs are accepted only in IDLE.
//  5. Assert reset (0) during round 3 WAIT -> all outputs at reset values immediately.
//     Next permutation is correct.
//  6. Watchdog build, stub never responds -> err=1 at TIMEOUT_CYCLES=64 after WAIT entry;
//     in_ready stays 0 until reset.

Source files
------------

// File: rtl/monolith_pkg.sv
// Shared defaults, state container type and scheduler FSM encoding for the Monolith round scheduler.
package monolith_pkg;

    localparam int DEF_WORD_WIDTH = 31;
    localparam int DEF_STATE_SIZE = 16;

    typedef logic [DEF_WORD_WIDTH-1:0] [0:DEF_STATE_SIZE-1] state_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } sched_state_e;

endpackage

// File: rtl/monolith_sched_watchdog.sv
// Per-round cycle counter with clear, enable and expired flag.
// Instantiated by monolith_round_scheduler only when MONOLITH_SCHED_WATCHDOG_EN is defined.
module monolith_sched_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CntW = $clog2(LIMIT + 1);

    logic [CntW-1:0] count_q, count_d;

    // Saturate at LIMIT so a stalled enable can never wrap back to a quiet count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CntW'(LIMIT))) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/monolith_round_scheduler.sv
// Sequences one Monolith round pipeline through NUM_ROUNDS iterations of a permutation.
// Define MONOLITH_SCHED_WATCHDOG_EN to add a per-round timeout that parks the FSM in ERROR.
module monolith_round_scheduler
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
    parameter int STATE_SIZE      = DEF_STATE_SIZE,
    parameter int NUM_ROUNDS      = 6,
    parameter int LAST_ROUND_ZERO = 1,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0]    in_state,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [WORD_WIDTH*STATE_SIZE-1:0]    out_state,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(NUM_ROUNDS)-1:0]       rc_addr,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0]    rc_data,
    output logic [WORD_WIDTH*STATE_SIZE-1:0]    round_state_in,
    output logic                                round_in_valid,
    output logic [WORD_WIDTH*STATE_SIZE-1:0]    round_constants,
    input  logic [WORD_WIDTH*STATE_SIZE-1:0]    round_state_out,
    input  logic                                round_out_valid,
    output logic                                busy,
    output logic                                err
);

    localparam int SW = WORD_WIDTH * STATE_SIZE;
    localparam int CW = $clog2(NUM_ROUNDS);
    localparam logic [CW-1:0] LAST_RND = CW'(NUM_ROUNDS - 1);

    sched_state_e    state_q, state_d;
    logic [CW-1:0]   round_cnt_q, round_cnt_d;
    logic [SW-1:0]   data_q, data_d;
    logic [SW-1:0]   const_q, const_d;

`ifdef MONOLITH_SCHED_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    monolith_sched_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expired_o(wd_expired)
    );

    assign err = (state_q == ERROR);
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign err            = 1'b0;
`endif

    // round_cnt doubles as the ROM address, so it must already hold the next round on FETCH entry.
    always_comb begin
        state_d        = state_q;
        round_cnt_d    = round_cnt_q;
        data_d         = data_q;
        const_d        = const_q;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        round_in_valid = 1'b0;
`ifdef MONOLITH_SCHED_WATCHDOG_EN
        wd_clear       = 1'b0;
        wd_enable      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d      = in_state;
                    round_cnt_d = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                if ((LAST_ROUND_ZERO != 0) && (round_cnt_q == LAST_RND)) begin
                    const_d = '0;
                end else begin
                    const_d = rc_data;
                end
                state_d = ISSUE;
            end
            ISSUE: begin
                round_in_valid = 1'b1;
`ifdef MONOLITH_SCHED_WATCHDOG_EN
                wd_clear       = 1'b1;
`endif
                state_d        = WAIT;
            end
            WAIT: begin
`ifdef MONOLITH_SCHED_WATCHDOG_EN
                wd_enable = 1'b1;
`endif
                if (round_out_valid) begin
                    data_d = round_state_out;
                    if (round_cnt_q == LAST_RND) begin
                        state_d = DONE;
                    end else begin
                        round_cnt_d = round_cnt_q + CW'(1);
                        state_d     = FETCH;
                    end
                end
`ifdef MONOLITH_SCHED_WATCHDOG_EN
                else if (wd_expired) begin
                    state_d = ERROR;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_cnt_q <= '0;
            data_q      <= '0;
            const_q     <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            data_q      <= data_d;
            const_q     <= const_d;
        end
    end

    assign rc_addr         = round_cnt_q;
    assign round_state_in  = data_q;
    assign out_state       = data_q;
    assign round_constants = const_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_monolith_round_scheduler.sv
// Self-checking bench for monolith_round_scheduler: stub round (5-cycle latency) and synchronous constant ROM.
// Watchdog sequence is compiled in when MONOLITH_SCHED_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_monolith_round_scheduler;

    localparam int WW      = 31;
    localparam int SS      = 16;
    localparam int NR      = 6;
    localparam int LROUND  = 5;
    localparam int SW      = WW * SS;
    localparam int EXP_LAT = 1 + NR * (3 + LROUND);
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [SW-1:0] in_state = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] out_state;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    rc_addr;
    logic [SW-1:0] rc_data = '0;
    logic [SW-1:0] round_state_in;
    logic          round_in_valid;
    logic [SW-1:0] round_constants;
    logic [SW-1:0] round_state_out;
    logic          round_out_valid;
    logic          busy;
    logic          err;

    logic [LROUND-1:0] pipeSr;
    logic              stubMute = 1'b0;
    logic              injectValid = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [SW-1:0] inState;
        int            holdCycles;
        bit            injectFetch;
        bit            keepValid;
        logic [SW-1:0] expOut;
    } vec_t;

    vec_t vecs [5];

    monolith_round_scheduler #(
        .WORD_WIDTH     (WW),
        .STATE_SIZE     (SS),
        .NUM_ROUNDS     (NR),
        .LAST_ROUND_ZERO(1),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_state       (in_state),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_state      (out_state),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .rc_addr        (rc_addr),
        .rc_data        (rc_data),
        .round_state_in (round_state_in),
        .round_in_valid (round_in_valid),
        .round_constants(round_constants),
        .round_state_out(round_state_out),
        .round_out_valid(round_out_valid),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] romWord(input int rnd);
        logic [SW-1:0] v;
        v = '0;
        for (int i = 0; i < SS; i++) v[i*WW +: WW] = WW'(32'h100 * rnd + i);
        return v;
    endfunction

    function automatic logic [SW-1:0] fillWords(input logic [31:0] base, input logic [31:0] step);
        logic [SW-1:0] v;
        logic [31:0]   w;
        v = '0;
        for (int i = 0; i < SS; i++) begin
            w = base + step * 32'(i);
            v[i*WW +: WW] = w[WW-1:0];
        end
        return v;
    endfunction

    // Toy round: mixes each word with its neighbour and the round constant.
    function automatic logic [SW-1:0] roundFn(input logic [SW-1:0] s, input logic [SW-1:0] c);
        logic [SW-1:0] r;
        logic [63:0]   acc;
        r = '0;
        for (int i = 0; i < SS; i++) begin
            acc = 64'(s[i*WW +: WW]) * 64'd3
                + 64'(s[((i + 1) % SS)*WW +: WW] ^ c[i*WW +: WW])
                + 64'(i);
            r[i*WW +: WW] = acc[WW-1:0];
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] expConstFor(input int rnd);
        return (rnd == NR - 1) ? {SW{1'b0}} : romWord(rnd);
    endfunction

    function automatic logic [SW-1:0] goldenPerm(input logic [SW-1:0] st);
        logic [SW-1:0] s;
        s = st;
        for (int r = 0; r < NR; r++) s = roundFn(s, expConstFor(r));
        return s;
    endfunction

    always @(posedge clk) rc_data <= romWord(int'(rc_addr));

    always @(posedge clk or negedge reset) begin
        if (!reset) pipeSr <= '0;
        else        pipeSr <= {pipeSr[LROUND-2:0], round_in_valid & ~stubMute};
    end

    assign round_out_valid = pipeSr[LROUND-1] | injectValid;
    assign round_state_out = roundFn(round_state_in, round_constants);

    task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkValue({tag, "_in_ready"}, int'(in_ready), 1);
        checkValue({tag, "_out_valid"}, int'(out_valid), 0);
        checkValue({tag, "_busy"}, int'(busy), 0);
        checkValue({tag, "_err"}, int'(err), 0);
        checkValue({tag, "_round_in_valid"}, int'(round_in_valid), 0);
        checkValue({tag, "_rc_addr"}, int'(rc_addr), 0);
        checkOutput({tag, "_round_constants"}, round_constants, '0);
        checkOutput({tag, "_round_state_in"}, round_state_in, '0);
        checkOutput({tag, "_out_state"}, out_state, '0);
    endtask

    // Runs one permutation from the current negedge and follows it cycle by cycle.
    task automatic applyStimulus(input vec_t v, input logic [SW-1:0] nextState);
        int            cyc;
        int            issueIdx;
        int            issueCyc;
        bit            done;
        logic [SW-1:0] modelState;
        logic [SW-1:0] curState;
        logic [SW-1:0] curConst;
        logic [SW-1:0] expConst;

        in_state = v.inState;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkValue("accept_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = v.keepValid;
        if (v.keepValid) begin
            in_state  = nextState;
            out_ready = 1'b1;
        end

        cyc        = 1;
        issueIdx   = 0;
        issueCyc   = -100;
        done       = 1'b0;
        modelState = v.inState;
        curState   = '0;
        curConst   = '0;
        while (!done && cyc <= 200) begin
            @(negedge clk);
            injectValid = v.injectFetch && (cyc == 1 || cyc == 9);
            if (v.keepValid && cyc == 45) out_ready = 1'b0;
            if (cyc == 1) begin
                checkValue("in_ready_drop", int'(in_ready), 0);
                checkValue("busy_set", int'(busy), 1);
            end
            if (cyc > issueCyc && cyc <= issueCyc + LROUND) begin
                checkOutput($sformatf("consts_wait_r%0d", issueIdx - 1), round_constants, curConst);
                checkOutput($sformatf("state_wait_r%0d", issueIdx - 1), round_state_in, curState);
                checkValue("in_ready_busy", int'(in_ready), 0);
            end
            if (round_in_valid) begin
                expConst = expConstFor(issueIdx);
                checkValue($sformatf("issue_cycle_r%0d", issueIdx), cyc, 3 + issueIdx * (3 + LROUND));
                checkValue($sformatf("rc_addr_r%0d", issueIdx), int'(rc_addr), issueIdx);
                checkOutput($sformatf("consts_r%0d", issueIdx), round_constants, expConst);
                checkOutput($sformatf("state_in_r%0d", issueIdx), round_state_in, modelState);
                curConst   = expConst;
                curState   = modelState;
                modelState = roundFn(modelState, expConst);
                issueCyc   = cyc;
                issueIdx++;
            end
            if (out_valid) begin
                done = 1'b1;
                checkValue("latency", cyc, EXP_LAT);
                checkValue("issue_count", issueIdx, NR);
                checkOutput("out_state", out_state, v.expOut);
                checkOutput("last_consts_zero", round_constants, '0);
                checkValue("in_ready_done", int'(in_ready), 0);
            end else begin
                cyc++;
            end
        end
        injectValid = 1'b0;
        if (!done) checkValue("done_timeout", 0, 1);

        for (int k = 0; k < v.holdCycles; k++) begin
            @(negedge clk);
            checkValue("hold_out_valid", int'(out_valid), 1);
            checkOutput("hold_out_state", out_state, v.expOut);
            checkValue("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkValue("in_ready_after_done", int'(in_ready), 1);
        checkValue("out_valid_after_done", int'(out_valid), 0);
        checkValue("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vec_t resetVec;

        vecs[0] = '{inState: fillWords(32'd1, 32'd0),                 holdCycles: 0,  injectFetch: 1'b0, keepValid: 1'b0, expOut: '0};
        vecs[1] = '{inState: fillWords(32'd0, 32'h1111),              holdCycles: 10, injectFetch: 1'b0, keepValid: 1'b0, expOut: '0};
        vecs[2] = '{inState: fillWords(32'd0, 32'd0),                 holdCycles: 1,  injectFetch: 1'b1, keepValid: 1'b0, expOut: '0};
        vecs[3] = '{inState: fillWords(32'h2AAAAAAA, 32'h55555555),   holdCycles: 1,  injectFetch: 1'b0, keepValid: 1'b1, expOut: '0};
        vecs[4] = '{inState: fillWords(32'h00012345, 32'h09E3779B),   holdCycles: 2,  injectFetch: 1'b1, keepValid: 1'b0, expOut: '0};
        for (int k = 0; k < 5; k++) vecs[k].expOut = goldenPerm(vecs[k].inState);

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("post_reset");

        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k], (k + 1 < 5) ? vecs[k + 1].inState : {SW{1'b0}});
        end

        // Abandon a permutation during round 3 WAIT, then prove the next one is clean.
        in_state = fillWords(32'd7, 32'd3);
        in_valid = 1'b1;
        checkValue("mid_reset_accept_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        checkValue("pre_reset_rc_addr", int'(rc_addr), 3);
        checkValue("pre_reset_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        resetVec = '{inState: fillWords(32'd7, 32'd3), holdCycles: 0, injectFetch: 1'b0, keepValid: 1'b0, expOut: '0};
        resetVec.expOut = goldenPerm(resetVec.inState);
        applyStimulus(resetVec, {SW{1'b0}});

`ifdef MONOLITH_SCHED_WATCHDOG_EN
        stubMute = 1'b1;
        in_state = fillWords(32'd5, 32'd1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (67) @(negedge clk);
        checkValue("wd_err_before_limit", int'(err), 0);
        @(negedge clk);
        checkValue("wd_err_at_limit", int'(err), 1);
        checkValue("wd_in_ready", int'(in_ready), 0);
        checkValue("wd_busy", int'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkValue("wd_err_sticky", int'(err), 1);
            checkValue("wd_in_ready_held", int'(in_ready), 0);
            checkValue("wd_out_valid_held", int'(out_valid), 0);
        end
        reset = 1'b0;
        #1;
        checkResetOutputs("wd_reset");
        @(negedge clk);
        reset = 1'b1;
        stubMute = 1'b0;
        @(negedge clk);
`else
        checkValue("err_tied_low", int'(err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
